vx_matrix_uop_seq: RTL and testbench

//  Sequencer that expands one matrix macro-instruction into a stream of scalar micro-ops.

---
 rtl/vx_matrix_uop_seq.sv | 236 +++++++++++++++++++++++
 tb/tb_vx_matrix_uop_seq.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vx_matrix_uop_seq.sv
// -----------------------------------------------------------------------------
// vx_matrix_uop_seq
//
// Expands one matrix macro-instruction into a stream of scalar micro-ops for a
// single issue slot. MLOAD and MMUL become multi-beat sequences; every other
// m_id passes through as a single micro-op. All register-index arithmetic and
// the op_mod override for MMUL are done here, so the downstream instruction
// buffer only has to store what it receives.
//
// Beat count N and per-beat fields (k = beat index, sums wrap to NR_BITS):
//   NORMAL : N = 1,              rd/rs1/rs2/op_mod unchanged
//   MLOAD  : N = max(row,1),     rd = rd+k, rs1/rs2/op_mod unchanged
//   MMUL   : N = row+1
//            k <  row : rd = rd+k, rs1 = rs1+k, rs2 = rs1+k+row, op_mod = 010
//            k == row : rd = rd,   rs1 = rd,    rs2 = rd+1,      op_mod = 000
//
// Ports
//   clk            clock
//   reset          asynchronous reset, active-low
//   flush          synchronous abort of the sequence in flight
//   in_valid       macro-op valid
//   in_ready       macro-op accepted when in_valid && in_ready
//   in_m_id        matrix instruction id
//   in_row_size    matrix row count
//   in_rd/rs1/rs2  base register indices
//   in_op_mod      op modifier for non-MMUL ops
//   in_meta        opaque payload, captured at accept
//   out_valid      micro-op valid
//   out_ready      downstream ready
//   out_rd/rs1/rs2 micro-op register indices
//   out_op_mod     micro-op modifier
//   out_idx        beat index within the sequence
//   out_last       final beat of the sequence
//   out_meta       captured in_meta, constant across the sequence
//   busy           a sequence is in flight
// -----------------------------------------------------------------------------
module vx_matrix_uop_seq #(
  parameter int         NR_BITS  = 6,
  parameter int         ROW_W    = 4,
  parameter int         META_W   = 64,
  parameter logic [3:0] MLOAD_ID = 4'd1,
  parameter logic [3:0] MMUL_ID  = 4'd3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         in_m_id,
  input  logic [ROW_W-1:0]   in_row_size,
  input  logic [NR_BITS-1:0] in_rd,
  input  logic [NR_BITS-1:0] in_rs1,
  input  logic [NR_BITS-1:0] in_rs2,
  input  logic [2:0]         in_op_mod,
  input  logic [META_W-1:0]  in_meta,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NR_BITS-1:0] out_rd,
  output logic [NR_BITS-1:0] out_rs1,
  output logic [NR_BITS-1:0] out_rs2,
  output logic [2:0]         out_op_mod,
  output logic [ROW_W-1:0]   out_idx,
  output logic               out_last,
  output logic [META_W-1:0]  out_meta,
  output logic               busy
);

  typedef enum logic {
    S_IDLE,
    S_SEQ
  } state_e;

  typedef enum logic [1:0] {
    K_NORMAL,
    K_MLOAD,
    K_MMUL
  } kind_e;

  // One fully-formed micro-op as presented on the outputs.
  typedef struct packed {
    logic [NR_BITS-1:0] rd;
    logic [NR_BITS-1:0] rs1;
    logic [NR_BITS-1:0] rs2;
    logic [2:0]         op_mod;
    logic               last;
  } beat_t;

  localparam logic [2:0] MMUL_BODY_MOD  = 3'b010;
  localparam logic [2:0] MMUL_FINAL_MOD = 3'b000;

  // Zero-extends (or truncates) a row-sized quantity into register-index width
  // so that index sums wrap modulo 2^NR_BITS.
  function automatic logic [NR_BITS-1:0] to_reg(input logic [ROW_W-1:0] v);
    return NR_BITS'(v);
  endfunction

  // Builds beat k of a macro-op from its captured base fields.
  function automatic beat_t make_beat(
    input kind_e              kind,
    input logic [NR_BITS-1:0] rd,
    input logic [NR_BITS-1:0] rs1,
    input logic [NR_BITS-1:0] rs2,
    input logic [2:0]         op_mod,
    input logic [ROW_W-1:0]   row,
    input logic [ROW_W-1:0]   k
  );
    beat_t b;
    b.rd     = rd;
    b.rs1    = rs1;
    b.rs2    = rs2;
    b.op_mod = op_mod;
    b.last   = 1'b1;
    case (kind)
      K_MLOAD: begin
        b.rd = rd + to_reg(k);
        // row_size 0 still issues one beat, so the last index is 0, not -1.
        b.last = (row == '0) ? (k == '0) : (k == row - ROW_W'(1));
      end
      K_MMUL: begin
        if (k == row) begin
          // Final beat rewrites the accumulator pair from the destination base.
          b.rs1    = rd;
          b.rs2    = rd + NR_BITS'(1);
          b.op_mod = MMUL_FINAL_MOD;
          b.last   = 1'b1;
        end else begin
          b.rd     = rd + to_reg(k);
          b.rs1    = rs1 + to_reg(k);
          b.rs2    = rs1 + to_reg(k) + to_reg(row);
          b.op_mod = MMUL_BODY_MOD;
          b.last   = 1'b0;
        end
      end
      default: ;
    endcase
    return b;
  endfunction

  // Sequencer state and captured macro fields.
  state_e              state_q;
  kind_e               kind_q;
  logic [NR_BITS-1:0]  rd_q;
  logic [NR_BITS-1:0]  rs1_q;
  logic [NR_BITS-1:0]  rs2_q;
  logic [2:0]          op_mod_q;
  logic [ROW_W-1:0]    row_q;
  logic [ROW_W-1:0]    idx_q;
  logic [META_W-1:0]   meta_q;
  beat_t               beat_q;

  // Next-beat candidates.
  kind_e               in_kind_d;
  beat_t               first_beat_d;
  beat_t               next_beat_d;
  logic [ROW_W-1:0]    next_idx_d;

  logic                accept;
  logic                fire;
  logic                advance;
  logic                retire;

  assign out_valid = (state_q == S_SEQ);
  assign busy      = out_valid;

  // A new macro-op may land in the same cycle the last beat of the previous
  // one is consumed, which keeps back-to-back sequences bubble-free.
  assign in_ready = !flush && (!out_valid || (out_ready && beat_q.last));
  assign accept   = in_valid && in_ready;
  assign fire     = out_valid && out_ready;
  assign advance  = fire && !beat_q.last;
  assign retire   = fire && beat_q.last && !accept;

  // NOTE: every variable driven from always_comb gets a default at the top so
  // no path can leave it unassigned and infer a latch.
  always_comb begin
    in_kind_d = K_NORMAL;
    if (in_m_id == MLOAD_ID) begin
      in_kind_d = K_MLOAD;
    end else if (in_m_id == MMUL_ID) begin
      in_kind_d = K_MMUL;
    end
    next_idx_d   = idx_q + ROW_W'(1);
    first_beat_d = make_beat(in_kind_d, in_rd, in_rs1, in_rs2, in_op_mod,
                             in_row_size, '0);
    next_beat_d  = make_beat(kind_q, rd_q, rs1_q, rs2_q, op_mod_q,
                             row_q, next_idx_d);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  // Data registers are reset as well so the outputs read as zero after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      kind_q   <= K_NORMAL;
      rd_q     <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      op_mod_q <= '0;
      row_q    <= '0;
      idx_q    <= '0;
      meta_q   <= '0;
      beat_q   <= '0;
    end else if (flush) begin
      // The held beat is dropped; payload registers are left as they are.
      state_q <= S_IDLE;
      idx_q   <= '0;
    end else if (accept) begin
      state_q  <= S_SEQ;
      kind_q   <= in_kind_d;
      rd_q     <= in_rd;
      rs1_q    <= in_rs1;
      rs2_q    <= in_rs2;
      op_mod_q <= in_op_mod;
      row_q    <= in_row_size;
      meta_q   <= in_meta;
      idx_q    <= '0;
      beat_q   <= first_beat_d;
    end else if (advance) begin
      idx_q  <= next_idx_d;
      beat_q <= next_beat_d;
    end else if (retire) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
    end
  end

  assign out_rd     = beat_q.rd;
  assign out_rs1    = beat_q.rs1;
  assign out_rs2    = beat_q.rs2;
  assign out_op_mod = beat_q.op_mod;
  assign out_last   = beat_q.last;
  assign out_idx    = idx_q;
  assign out_meta   = meta_q;

endmodule

// File: tb/tb_vx_matrix_uop_seq.sv
// -----------------------------------------------------------------------------
// tb_vx_matrix_uop_seq
//
// Scoreboard bench for vx_matrix_uop_seq. Each accepted macro-op pushes its
// expected beats onto a queue; a monitor on the falling edge compares the held
// beat against the queue head (popping it when the beat is consumed).
// Inputs change one time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_vx_matrix_uop_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_m_id;
  logic [3:0]  in_row_size;
  logic [5:0]  in_rd;
  logic [5:0]  in_rs1;
  logic [5:0]  in_rs2;
  logic [2:0]  in_op_mod;
  logic [63:0] in_meta;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  out_rd;
  logic [5:0]  out_rs1;
  logic [5:0]  out_rs2;
  logic [2:0]  out_op_mod;
  logic [3:0]  out_idx;
  logic        out_last;
  logic [63:0] out_meta;
  logic        busy;

  vx_matrix_uop_seq dut (
    .clk         (clk),
    .reset       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_m_id     (in_m_id),
    .in_row_size (in_row_size),
    .in_rd       (in_rd),
    .in_rs1      (in_rs1),
    .in_rs2      (in_rs2),
    .in_op_mod   (in_op_mod),
    .in_meta     (in_meta),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_rd      (out_rd),
    .out_rs1     (out_rs1),
    .out_rs2     (out_rs2),
    .out_op_mod  (out_op_mod),
    .out_idx     (out_idx),
    .out_last    (out_last),
    .out_meta    (out_meta),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0]  rd;
    logic [5:0]  rs1;
    logic [5:0]  rs2;
    logic [2:0]  op_mod;
    logic [3:0]  idx;
    logic        last;
    logic [63:0] meta;
  } exp_t;

  exp_t exp_q[$];
  exp_t head;
  int   n_checks = 0;
  int   n_errors = 0;
  bit   rnd_done = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference expansion, written directly from the beat table with integer math.
  task automatic push_expected(input int id, input int row, input int rd, input int rs1,
                               input int rs2, input int op_mod, input logic [63:0] meta);
    int   n;
    exp_t e;
    if (id == 1)      n = (row == 0) ? 1 : row;
    else if (id == 3) n = row + 1;
    else              n = 1;
    for (int k = 0; k < n; k++) begin
      e.idx  = 4'(k);
      e.last = (k == n - 1);
      e.meta = meta;
      if (id == 3 && k < row) begin
        e.rd = 6'((rd + k) % 64);  e.rs1 = 6'((rs1 + k) % 64);
        e.rs2 = 6'((rs1 + k + row) % 64);  e.op_mod = 3'd2;
      end else if (id == 3) begin
        e.rd = 6'(rd);  e.rs1 = 6'(rd);  e.rs2 = 6'((rd + 1) % 64);  e.op_mod = 3'd0;
      end else if (id == 1) begin
        e.rd = 6'((rd + k) % 64);  e.rs1 = 6'(rs1);  e.rs2 = 6'(rs2);  e.op_mod = 3'(op_mod);
      end else begin
        e.rd = 6'(rd);  e.rs1 = 6'(rs1);  e.rs2 = 6'(rs2);  e.op_mod = 3'(op_mod);
      end
      exp_q.push_back(e);
    end
  endtask

  // Monitor: the held beat must match the queue head whether or not it fires.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      check("busy_with_valid", 64'(busy), 64'd1);
      if (exp_q.size() == 0) begin
        check("beat_not_expected", 64'(out_valid), 64'd0);
      end else begin
        head = exp_q[0];
        check(out_ready ? "beat" : "held_beat",
              64'({out_rd, out_rs1, out_rs2, out_op_mod, out_idx, out_last}),
              64'({head.rd, head.rs1, head.rs2, head.op_mod, head.idx, head.last}));
        check("meta", out_meta, head.meta);
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Presents one macro-op until accepted; returns one unit after the accepting edge.
  task automatic send(input int id, input int row, input int rd, input int rs1,
                      input int rs2, input int op_mod);
    logic [63:0] meta;
    bit          done = 0;
    meta        = {$urandom, $urandom};
    in_valid    = 1'b1;
    in_m_id     = 4'(id);
    in_row_size = 4'(row);
    in_rd       = 6'(rd);
    in_rs1      = 6'(rs1);
    in_rs2      = 6'(rs2);
    in_op_mod   = 3'(op_mod);
    in_meta     = meta;
    for (int c = 0; c < 200 && !done; c++) begin
      #1;
      if (in_ready) begin
        push_expected(id, row, rd, rs1, rs2, op_mod, meta);
        done = 1;
      end
      sync();
    end
    in_valid = 1'b0;
    if (!done) check("accept_timeout", 64'(done), 64'd1);
  endtask

  task automatic drain();
    int c = 0;
    while ((exp_q.size() != 0 || out_valid) && c < 300) begin
      sync();
      c++;
    end
    check("drain_in_time", 64'(c < 300), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    logic [3:0] ids [6];
    ids = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd15};

    rst_n = 1'b0;  flush = 1'b0;  in_valid = 1'b0;  out_ready = 1'b1;
    in_m_id = '0;  in_row_size = '0;  in_rd = '0;  in_rs1 = '0;  in_rs2 = '0;
    in_op_mod = '0;  in_meta = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_idx", 64'(out_idx), 64'd0);
    check("rst_rd", 64'(out_rd), 64'd0);
    check("rst_meta", out_meta, 64'd0);
    rst_n = 1'b1;
    sync();
    check("idle_in_ready", 64'(in_ready), 64'd1);

    // NORMAL: one beat, ready for the next macro-op in the same cycle.
    send(0, 0, 5, 7, 9, 5);
    check("normal_in_ready_same_cycle", 64'(in_ready), 64'd1);
    drain();

    // MLOAD rd=8 row=4, then MMUL rd=16 rs1=0 row=2.
    send(1, 4, 8, 3, 4, 6);
    drain();
    send(3, 2, 16, 0, 20, 5);
    drain();

    // Back-to-back macro-ops with no gap on the input side.
    send(0, 0, 1, 2, 3, 1);
    send(1, 2, 40, 5, 6, 3);
    send(3, 1, 50, 10, 11, 7);
    drain();

    // Backpressure on beat 1 of MLOAD row=3.
    send(1, 3, 20, 1, 2, 1);
    sync();
    check("bp_idx_before_stall", 64'(out_idx), 64'd1);
    out_ready = 1'b0;
    repeat (3) sync();
    check("bp_idx_after_stall", 64'(out_idx), 64'd1);
    out_ready = 1'b1;
    drain();

    // Wrap and edge cases.
    send(1, 2, 63, 9, 9, 2);    // rd 63 then 0
    drain();
    send(3, 0, 10, 4, 5, 7);    // single final beat
    drain();
    send(1, 0, 33, 1, 1, 4);    // MLOAD row 0 still one beat
    drain();
    send(3, 15, 60, 50, 0, 1);  // full-width row count, 16 beats
    drain();

    // Flush while beat 2 of MLOAD row=4 is held.
    send(1, 4, 8, 0, 0, 3);
    sync();
    sync();
    check("flush_pre_idx", 64'(out_idx), 64'd2);
    out_ready   = 1'b0;
    flush       = 1'b1;
    in_valid    = 1'b1;
    in_m_id     = 4'd1;
    in_row_size = 4'd2;
    #1;
    check("flush_in_ready", 64'(in_ready), 64'd0);
    sync();
    flush    = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_idx", 64'(out_idx), 64'd0);
    out_ready = 1'b1;
    send(1, 3, 30, 2, 2, 0);
    check("post_flush_idx", 64'(out_idx), 64'd0);
    drain();

    // Random macro-ops under random backpressure.
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          send(int'(ids[$urandom_range(0, 5)]), int'($urandom_range(0, 15)),
               int'($urandom_range(0, 63)), int'($urandom_range(0, 63)),
               int'($urandom_range(0, 63)), int'($urandom_range(0, 7)));
        end
        drain();
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          sync();
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    sync();

    // Asynchronous reset in the middle of an MMUL sequence.
    send(3, 5, 12, 2, 3, 0);
    sync();
    sync();
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", 64'(out_valid), 64'd0);
    check("async_rst_busy", 64'(busy), 64'd0);
    check("async_rst_idx", 64'(out_idx), 64'd0);
    check("async_rst_rd", 64'(out_rd), 64'd0);
    exp_q.delete();
    sync();
    sync();
    rst_n = 1'b1;
    sync();
    send(0, 0, 21, 22, 23, 6);
    drain();

    check("queue_empty_at_end", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
